// File: rtl/yurut_sonuc_kuyrugu.sv
// Execute-stage result collector: dispatches to multi-cycle units,
// retires results in program order and discards flushed in-flight results.
module yurut_sonuc_kuyrugu #(
   parameter int BIRIM_SAYISI = 4,
   parameter int DERINLIK     = 4,
   parameter int VERI_W       = 32
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           durdur_i,
   input  logic                           bosalt_i,
   input  logic                           buyruk_gecerli_i,
   input  logic [BIRIM_SAYISI-1:0]        birim_sec_i,
   input  logic [4:0]                     hedef_yazmaci_i,
   input  logic                           yazmaca_yaz_i,
   input  logic [2:0]                     load_save_buyrugu_i,
   input  logic                           bellege_yaz_i,
   input  logic                           bellekten_oku_i,
   input  logic [VERI_W-1:0]              yazmac_degeri2_i,
   output logic [BIRIM_SAYISI-1:0]        birim_baslat_o,
   input  logic [BIRIM_SAYISI-1:0]        birim_hazir_i,
   input  logic [BIRIM_SAYISI*VERI_W-1:0] birim_sonuc_i,
   output logic                           sonuc_gecerli_o,
   output logic [VERI_W-1:0]              hedef_yazmac_verisi_o,
   output logic [VERI_W-1:0]              bellek_adresi_o,
   output logic [VERI_W-1:0]              bellek_veri_o,
   output logic [4:0]                     hedef_yazmaci_o,
   output logic                           yazmaca_yaz_o,
   output logic [2:0]                     load_save_buyrugu_o,
   output logic                           bellege_yaz_o,
   output logic                           bellekten_oku_o,
   output logic                           yurut_stall_o,
   output logic                           gecersiz_sec_o,
   output logic [$clog2(DERINLIK):0]      doluluk_o
);
   localparam int UW = $clog2(BIRIM_SAYISI);
   localparam int PW = $clog2(DERINLIK);
   localparam int CW = PW + 1;
   localparam int IW = PW + 4;

   logic [UW-1:0]     birim_q [DERINLIK];
   logic [4:0]        hedef_q [DERINLIK];
   logic [2:0]        ls_q    [DERINLIK];
   logic [VERI_W-1:0] veri2_q [DERINLIK];
   logic [VERI_W-1:0] sonuc_q [DERINLIK];
   logic [DERINLIK-1:0] yaz_q, bw_q, bo_q, tamam_q;
   logic [PW-1:0] bas_q, kuyruk_q;
   logic [CW-1:0] sayi_q;
   logic [IW-1:0] iptal_q [BIRIM_SAYISI];

   logic tek_sicak, istek_ok, kabul, cikar, bas_byp;
   logic [UW-1:0] sec_idx, bas_birim;
   logic [BIRIM_SAYISI-1:0] bulundu, yakala;
   logic [PW-1:0] hedef_idx [BIRIM_SAYISI];
   logic [CW-1:0] ucusta [BIRIM_SAYISI];
   logic [VERI_W-1:0] sonuc_k [BIRIM_SAYISI];
   logic [VERI_W-1:0] bas_sonuc;
   logic [PW-1:0] ara_idx;

   assign yurut_stall_o = (sayi_q == CW'(DERINLIK));
   assign doluluk_o     = sayi_q;

   always_comb begin
      tek_sicak = (birim_sec_i != '0) &&
         ((birim_sec_i & (birim_sec_i - {{(BIRIM_SAYISI-1){1'b0}}, 1'b1})) == '0);
      sec_idx = '0;
      for (int k = 0; k < BIRIM_SAYISI; k++)
         if (birim_sec_i[k]) sec_idx = UW'(k);
      istek_ok = buyruk_gecerli_i & ~yurut_stall_o & ~durdur_i &
                 ~bosalt_i & ~rst_i;
      kabul = istek_ok & tek_sicak;
      birim_baslat_o = kabul ? birim_sec_i : '0;
   end

   // Per unit: oldest waiting entry and number of waiting entries.
   always_comb begin
      ara_idx = '0;
      for (int k = 0; k < BIRIM_SAYISI; k++) begin
         bulundu[k]   = 1'b0;
         hedef_idx[k] = '0;
         ucusta[k]    = '0;
         sonuc_k[k]   = birim_sonuc_i[k*VERI_W +: VERI_W];
         for (int i = 0; i < DERINLIK; i++) begin
            ara_idx = bas_q + PW'(i);
            if (CW'(i) < sayi_q && birim_q[ara_idx] == UW'(k) &&
                !tamam_q[ara_idx]) begin
               ucusta[k] = ucusta[k] + CW'(1);
               if (!bulundu[k]) begin
                  bulundu[k]   = 1'b1;
                  hedef_idx[k] = ara_idx;
               end
            end
         end
         yakala[k] = birim_hazir_i[k] && (iptal_q[k] == '0) && bulundu[k];
      end
   end

   always_comb begin
      bas_birim = birim_q[bas_q];
      bas_byp   = (sayi_q != '0) && !tamam_q[bas_q] && yakala[bas_birim];
      bas_sonuc = tamam_q[bas_q] ? sonuc_q[bas_q] : sonuc_k[bas_birim];
      cikar     = ~durdur_i & ~bosalt_i & (sayi_q != '0) &
                  (tamam_q[bas_q] | bas_byp);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bas_q    <= '0;
         kuyruk_q <= '0;
         sayi_q   <= '0;
         tamam_q  <= '0;
         yaz_q    <= '0;
         bw_q     <= '0;
         bo_q     <= '0;
         for (int i = 0; i < DERINLIK; i++) begin
            birim_q[i] <= '0;
            hedef_q[i] <= '0;
            ls_q[i]    <= '0;
            veri2_q[i] <= '0;
            sonuc_q[i] <= '0;
         end
         for (int k = 0; k < BIRIM_SAYISI; k++) iptal_q[k] <= '0;
         gecersiz_sec_o        <= 1'b0;
         sonuc_gecerli_o       <= 1'b0;
         hedef_yazmac_verisi_o <= '0;
         bellek_adresi_o       <= '0;
         bellek_veri_o         <= '0;
         hedef_yazmaci_o       <= '0;
         yazmaca_yaz_o         <= 1'b0;
         load_save_buyrugu_o   <= '0;
         bellege_yaz_o         <= 1'b0;
         bellekten_oku_o       <= 1'b0;
      end else begin
         gecersiz_sec_o <= istek_ok & ~tek_sicak;
         for (int k = 0; k < BIRIM_SAYISI; k++) begin
            if (yakala[k]) begin
               sonuc_q[hedef_idx[k]] <= sonuc_k[k];
               tamam_q[hedef_idx[k]] <= 1'b1;
            end
            // A result captured in the flush cycle is not counted as in flight.
            if (bosalt_i)
               iptal_q[k] <= iptal_q[k] + IW'(ucusta[k]) -
                  IW'(birim_hazir_i[k] && (iptal_q[k] != '0 || ucusta[k] != '0));
            else if (birim_hazir_i[k] && iptal_q[k] != '0)
               iptal_q[k] <= iptal_q[k] - IW'(1);
         end
         if (bosalt_i) begin
            bas_q                 <= '0;
            kuyruk_q              <= '0;
            sayi_q                <= '0;
            tamam_q               <= '0;
            sonuc_gecerli_o       <= 1'b0;
            hedef_yazmac_verisi_o <= '0;
            bellek_adresi_o       <= '0;
            bellek_veri_o         <= '0;
            hedef_yazmaci_o       <= '0;
            yazmaca_yaz_o         <= 1'b0;
            load_save_buyrugu_o   <= '0;
            bellege_yaz_o         <= 1'b0;
            bellekten_oku_o       <= 1'b0;
         end else begin
            if (kabul) begin
               birim_q[kuyruk_q] <= sec_idx;
               hedef_q[kuyruk_q] <= hedef_yazmaci_i;
               ls_q[kuyruk_q]    <= load_save_buyrugu_i;
               veri2_q[kuyruk_q] <= yazmac_degeri2_i;
               yaz_q[kuyruk_q]   <= yazmaca_yaz_i;
               bw_q[kuyruk_q]    <= bellege_yaz_i;
               bo_q[kuyruk_q]    <= bellekten_oku_i;
               tamam_q[kuyruk_q] <= 1'b0;
               kuyruk_q          <= kuyruk_q + PW'(1);
            end
            if (cikar) bas_q <= bas_q + PW'(1);
            case ({kabul, cikar})
               2'b10:   sayi_q <= sayi_q + CW'(1);
               2'b01:   sayi_q <= sayi_q - CW'(1);
               default: sayi_q <= sayi_q;
            endcase
            if (!durdur_i) begin
               sonuc_gecerli_o       <= cikar;
               hedef_yazmac_verisi_o <= cikar ? bas_sonuc : '0;
               bellek_adresi_o       <= cikar ? bas_sonuc : '0;
               bellek_veri_o         <= cikar ? veri2_q[bas_q] : '0;
               hedef_yazmaci_o       <= cikar ? hedef_q[bas_q] : '0;
               yazmaca_yaz_o         <= cikar & yaz_q[bas_q];
               load_save_buyrugu_o   <= cikar ? ls_q[bas_q] : '0;
               bellege_yaz_o         <= cikar & bw_q[bas_q];
               bellekten_oku_o       <= cikar & bo_q[bas_q];
            end
         end
      end
   end
endmodule

// File: tb/tb_yurut_sonuc_kuyrugu.sv
// Scoreboard bench for yurut_sonuc_kuyrugu with a queue-level model
// and a behavioural functional-unit responder.
module tb_yurut_sonuc_kuyrugu;
   localparam int B = 4;
   localparam int D = 4;
   localparam int W = 32;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic rst_i, durdur_i, bosalt_i, buyruk_gecerli_i;
   logic [B-1:0] birim_sec_i, birim_baslat_o, birim_hazir_i;
   logic [4:0] hedef_yazmaci_i, hedef_yazmaci_o;
   logic yazmaca_yaz_i, bellege_yaz_i, bellekten_oku_i;
   logic [2:0] load_save_buyrugu_i, load_save_buyrugu_o;
   logic [W-1:0] yazmac_degeri2_i;
   logic [B*W-1:0] birim_sonuc_i;
   logic sonuc_gecerli_o, yazmaca_yaz_o, bellege_yaz_o, bellekten_oku_o;
   logic [W-1:0] hedef_yazmac_verisi_o, bellek_adresi_o, bellek_veri_o;
   logic yurut_stall_o, gecersiz_sec_o;
   logic [$clog2(D):0] doluluk_o;

   yurut_sonuc_kuyrugu #(.BIRIM_SAYISI(B), .DERINLIK(D), .VERI_W(W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .durdur_i(durdur_i),
      .bosalt_i(bosalt_i), .buyruk_gecerli_i(buyruk_gecerli_i),
      .birim_sec_i(birim_sec_i), .hedef_yazmaci_i(hedef_yazmaci_i),
      .yazmaca_yaz_i(yazmaca_yaz_i),
      .load_save_buyrugu_i(load_save_buyrugu_i),
      .bellege_yaz_i(bellege_yaz_i), .bellekten_oku_i(bellekten_oku_i),
      .yazmac_degeri2_i(yazmac_degeri2_i),
      .birim_baslat_o(birim_baslat_o), .birim_hazir_i(birim_hazir_i),
      .birim_sonuc_i(birim_sonuc_i), .sonuc_gecerli_o(sonuc_gecerli_o),
      .hedef_yazmac_verisi_o(hedef_yazmac_verisi_o),
      .bellek_adresi_o(bellek_adresi_o), .bellek_veri_o(bellek_veri_o),
      .hedef_yazmaci_o(hedef_yazmaci_o), .yazmaca_yaz_o(yazmaca_yaz_o),
      .load_save_buyrugu_o(load_save_buyrugu_o),
      .bellege_yaz_o(bellege_yaz_o), .bellekten_oku_o(bellekten_oku_o),
      .yurut_stall_o(yurut_stall_o), .gecersiz_sec_o(gecersiz_sec_o),
      .doluluk_o(doluluk_o)
   );

   typedef struct {
      int unsigned unit;
      logic [4:0] rd;
      logic we;
      logic [2:0] ls;
      logic mw;
      logic mr;
      logic [W-1:0] d2;
      logic [W-1:0] res;
      bit done;
   } ent_t;

   typedef struct {
      int unsigned unit;
      int due;
      logic [W-1:0] res;
   } job_t;

   ent_t mq[$];
   ent_t exq[$];
   job_t jobs[$];
   int cancel [B];
   int last_due [B];
   int cyc = 0;
   int total = 0;
   int bad = 0;
   bit rst_p, bos_p, dur_p, gec_exp;
   int plan_lat = 1;
   logic [W-1:0] plan_res = '0;
   logic [107:0] last_out = '0;

   task automatic chk(string nm, logic [127:0] got, logic [127:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
      end
   endtask

   // Reference model: in-order list of outstanding instructions.
   initial begin
      for (int k = 0; k < B; k++) begin
         cancel[k] = 0;
         last_due[k] = 0;
      end
      forever begin
         @(posedge clk_i);
         begin
            int pre;
            bit acc, oh;
            rst_p = rst_i;
            bos_p = bosalt_i;
            dur_p = durdur_i;
            pre = mq.size();
            oh = ($countones(birim_sec_i) == 1);
            acc = !rst_i && buyruk_gecerli_i && pre < D &&
                  !durdur_i && !bosalt_i;
            gec_exp = acc && !oh;
            acc = acc && oh;
            if (rst_i) begin
               mq.delete();
               for (int k = 0; k < B; k++) cancel[k] = 0;
            end else begin
               for (int k = 0; k < B; k++) begin
                  if (birim_hazir_i[k]) begin
                     if (cancel[k] > 0) cancel[k]--;
                     else begin
                        for (int i = 0; i < mq.size(); i++) begin
                           if (mq[i].unit == k && !mq[i].done) begin
                              mq[i].done = 1'b1;
                              mq[i].res = birim_sonuc_i[k*W +: W];
                              break;
                           end
                        end
                     end
                  end
               end
               if (bosalt_i) begin
                  for (int k = 0; k < B; k++) begin
                     int n;
                     n = 0;
                     for (int i = 0; i < mq.size(); i++)
                        if (mq[i].unit == k && !mq[i].done) n++;
                     cancel[k] += n;
                  end
                  mq.delete();
               end else begin
                  if (!durdur_i && mq.size() > 0 && mq[0].done) begin
                     exq.push_back(mq[0]);
                     void'(mq.pop_front());
                  end
                  if (acc) begin
                     ent_t e;
                     job_t j;
                     int u, due;
                     u = 0;
                     for (int k = 0; k < B; k++) if (birim_sec_i[k]) u = k;
                     e.unit = u;
                     e.rd = hedef_yazmaci_i;
                     e.we = yazmaca_yaz_i;
                     e.ls = load_save_buyrugu_i;
                     e.mw = bellege_yaz_i;
                     e.mr = bellekten_oku_i;
                     e.d2 = yazmac_degeri2_i;
                     e.res = '0;
                     e.done = 1'b0;
                     mq.push_back(e);
                     due = cyc + plan_lat;
                     if (due <= last_due[u]) due = last_due[u] + 1;
                     last_due[u] = due;
                     j.unit = u;
                     j.due = due;
                     j.res = plan_res;
                     jobs.push_back(j);
                  end
               end
            end
            cyc++;
         end
      end
   end

   // Functional units: each returns its own jobs in start order.
   initial begin
      birim_hazir_i = '0;
      birim_sonuc_i = '0;
      forever begin
         @(posedge clk_i);
         #1;
         begin
            logic [B-1:0] hz;
            logic [B*W-1:0] bus;
            hz = '0;
            bus = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < B; k++) begin
               for (int i = 0; i < jobs.size(); i++) begin
                  if (jobs[i].unit == k) begin
                     if (jobs[i].due <= cyc) begin
                        hz[k] = 1'b1;
                        bus[k*W +: W] = jobs[i].res;
                        jobs.delete(i);
                     end
                     break;
                  end
               end
            end
            birim_hazir_i = hz;
            birim_sonuc_i = bus;
         end
      end
   end

   // Monitor: pops the scoreboard whenever a fresh retire is presented.
   initial begin
      forever begin
         @(negedge clk_i);
         begin
            logic [107:0] cur;
            ent_t e;
            bit oh;
            cur = {sonuc_gecerli_o, hedef_yazmac_verisi_o, bellek_adresi_o,
                   bellek_veri_o, hedef_yazmaci_o, yazmaca_yaz_o,
                   load_save_buyrugu_o, bellege_yaz_o, bellekten_oku_o};
            if (dur_p && !rst_p && !bos_p) chk("hold", cur, last_out);
            else if (sonuc_gecerli_o) begin
               if (exq.size() == 0) chk("unexpected_retire", cur, '0);
               else begin
                  e = exq.pop_front();
                  chk("retire", cur, {1'b1, e.res, e.res, e.d2, e.rd, e.we,
                                      e.ls, e.mw, e.mr});
               end
            end else chk("idle_out", cur, '0);
            if (exq.size() != 0) begin
               chk("missing_retire", exq.size(), 0);
               exq.delete();
            end
            last_out = cur;
            chk("doluluk", doluluk_o, mq.size());
            chk("stall", yurut_stall_o, mq.size() == D);
            chk("gecersiz", gecersiz_sec_o, gec_exp);
            oh = ($countones(birim_sec_i) == 1);
            chk("baslat", birim_baslat_o,
                (!rst_i && buyruk_gecerli_i && mq.size() < D && !durdur_i &&
                 !bosalt_i && oh) ? birim_sec_i : '0);
         end
      end
   end

   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic rnd_fields();
      hedef_yazmaci_i = 5'($urandom);
      yazmaca_yaz_i = 1'($urandom);
      load_save_buyrugu_i = 3'($urandom);
      bellege_yaz_i = 1'($urandom);
      bellekten_oku_i = 1'($urandom);
      yazmac_degeri2_i = $urandom;
   endtask

   task automatic idle();
      buyruk_gecerli_i = 1'b0;
      durdur_i = 1'b0;
      bosalt_i = 1'b0;
      birim_sec_i = '0;
   endtask

   task automatic issue(int u, int lat, logic [W-1:0] res);
      rnd_fields();
      buyruk_gecerli_i = 1'b1;
      birim_sec_i = B'(1 << u);
      plan_lat = lat;
      plan_res = res;
   endtask

   initial begin
      rst_i = 1'b1;
      idle();
      rnd_fields();
      step(3);
      rst_i = 1'b0;
      step(2);
      // in-order retire, out-of-order completion
      issue(0, 3, 32'h11);
      step();
      issue(1, 1, 32'h22);
      step();
      idle();
      step(8);
      // full queue
      for (int i = 0; i < 5; i++) begin
         issue(3, 30, 32'h100 + i);
         step();
      end
      idle();
      step(50);
      // flush with results in flight
      issue(2, 8, 32'hdead);
      step();
      issue(2, 8, 32'hbeef);
      step();
      idle();
      bosalt_i = 1'b1;
      step();
      idle();
      step(15);
      issue(2, 2, 32'h33);
      step();
      idle();
      step(6);
      // bad selects
      rnd_fields();
      buyruk_gecerli_i = 1'b1;
      birim_sec_i = 4'b0011;
      step();
      birim_sec_i = 4'b0000;
      step();
      idle();
      step(3);
      // freeze while the head completes
      issue(1, 2, 32'h44);
      step();
      idle();
      durdur_i = 1'b1;
      step(3);
      durdur_i = 1'b0;
      step(5);
      // reset with three entries queued
      for (int i = 0; i < 3; i++) begin
         issue(0, 12, 32'h200 + i);
         step();
      end
      idle();
      rst_i = 1'b1;
      step(2);
      rst_i = 1'b0;
      step(25);
      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rnd_fields();
         buyruk_gecerli_i = ($urandom_range(0, 99) < 65);
         if ($urandom_range(0, 9) == 0) birim_sec_i = B'($urandom);
         else birim_sec_i = B'(1 << $urandom_range(0, B - 1));
         plan_lat = $urandom_range(1, 6);
         plan_res = $urandom;
         durdur_i = ($urandom_range(0, 9) == 0);
         bosalt_i = ($urandom_range(0, 29) == 0);
         rst_i = ($urandom_range(0, 399) == 0);
         step();
      end
      idle();
      rst_i = 1'b0;
      step(100);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/yurut_sonuc_kuyrugu.md
# yurut_sonuc_kuyrugu

Parametrised execute-stage result collector sitting between decode/issue and the memory/writeback stages. It dispatches each issued instruction to one of `BIRIM_SAYISI` multi-cycle functional units (AMB, yapay zeka, kriptografi, …) and holds that instruction's side-band fields in an in-order queue of depth `DERINLIK`. It retires results strictly in program order. Unlike the fixed single-instruction execute wrapper, it tracks several outstanding operations, and after a flush it discards results that were still in flight.

## Interface
- `BIRIM_SAYISI`, default 4: number of functional-unit channels (≥2).
- `DERINLIK`, default 4: queue entries (power of two, ≥2).
- `VERI_W`, default 32: result/data width.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `durdur_i` in 1: global freeze.
- `bosalt_i` in 1: flush the queue (branch misprediction or jump).
- `buyruk_gecerli_i` in 1: issue request.
- `birim_sec_i` in `BIRIM_SAYISI`: one-hot target unit.
- `hedef_yazmaci_i` in 5, `yazmaca_yaz_i` in 1, `load_save_buyrugu_i` in 3, `bellege_yaz_i` in 1, `bellekten_oku_i` in 1: side-band fields.
- `yazmac_degeri2_i` in `VERI_W`: store data.
- `birim_baslat_o` out `BIRIM_SAYISI`: one-cycle start pulse to the selected unit.
- `birim_hazir_i` in `BIRIM_SAYISI`: per-unit result-valid pulse.
- `birim_sonuc_i` in `BIRIM_SAYISI*VERI_W`: flattened results; unit k occupies `[k*VERI_W +: VERI_W]`.
- `sonuc_gecerli_o` out 1: retire pulse.
- `hedef_yazmac_verisi_o`, `bellek_adresi_o`, `bellek_veri_o` out `VERI_W`.
- `hedef_yazmaci_o` out 5, `yazmaca_yaz_o` out 1, `load_save_buyrugu_o` out 3, `bellege_yaz_o` out 1, `bellekten_oku_o` out 1.
- `yurut_stall_o` out 1: queue full.
- `gecersiz_sec_o` out 1: pulse when an issue is rejected for a bad `birim_sec_i`.
- `doluluk_o` out `$clog2(DERINLIK)+1`: current entry count.

## Operation
**Issue acceptance**
- An issue is accepted when `buyruk_gecerli_i & ~yurut_stall_o & ~durdur_i & ~bosalt_i` and `birim_sec_i` is exactly one-hot.
- On accept, `birim_baslat_o` equals `birim_sec_i` in the same cycle (combinational). The entry is written at the tail, holding the unit index, the side-band fields, `yazmac_degeri2_i`, and `tamam=0`.
- If the request is otherwise acceptable but `birim_sec_i` is zero or multi-hot, nothing is queued, no start pulse is issued, and `gecersiz_sec_o` pulses for one cycle (registered).

**Result capture**
- Each unit returns its results in its own start order.
- On `birim_hazir_i[k]`, the result is written into the oldest entry with unit index k and `tamam=0`, and that entry's `tamam` is set to 1.
- Exception: if `iptal_sayaci[k]` is nonzero, the result is dropped and the counter decrements.
- A `birim_hazir_i` pulse is honoured even while `durdur_i` is high.
- A pulse for a unit with no waiting entry and a zero `iptal_sayaci` is ignored.

**Retire**
- The head retires when `~durdur_i` and either the head has `tamam=1`, or `birim_hazir_i` is high for the head's unit this cycle (bypass).
- On retire, the output registers load the head's fields and result, `sonuc_gecerli_o` is set to 1, and the head pointer advances.
- `bellek_adresi_o` and `hedef_yazmac_verisi_o` both carry the result. `bellek_veri_o` carries the stored `yazmac_degeri2_i`.
- When not retiring, `sonuc_gecerli_o` and all output registers load 0.

**Flush (`bosalt_i`)**
- Pointers, count and all `tamam` flags are cleared, and output registers are cleared.
- For every unit k, `iptal_sayaci[k]` is incremented by that unit's in-flight count: entries with unit k and `tamam=0`, excluding any whose result arrives in the same cycle.
- If issue and flush coincide, the issue is not accepted.

**Stall and freeze**
- `yurut_stall_o = (doluluk_o == DERINLIK)`. A retire in the same cycle does not lift the stall; there is no full pass-through.
- `durdur_i` blocks issue and retire and holds the output registers. Result capture continues.

**Reset (`rst_i`)**
- Has priority over everything.
- All outputs, pointers, counters, `tamam` flags and `iptal_sayaci` go to 0 at the next edge, including during an operation in progress.

**Count**
- `doluluk_o` changes by +1 on accept only, −1 on retire only, and 0 when both occur in the same cycle.
- Pointers wrap modulo `DERINLIK`.

## Timing
- Start pulse: same cycle as accept.
- Unit with result pulse at cycle t+L after issue at t: retire outputs are valid at t+L+1 via the bypass, provided the entry is at the head.
- Result that is already complete at the head: retires on the next edge, giving one result per cycle throughput.
- `yurut_stall_o` asserts in the cycle after the accept that fills the queue.
- Reset: all outputs read 0 from the first edge with `rst_i=1`.

## Test plan
- **In-order retire with out-of-order completion.** Issue A to unit 0 (hazir at +3, result 0x11) and B to unit 1 (hazir at +1, result 0x22). Required: A retires first (`hedef_yazmac_verisi_o=0x11`), then B (0x22) on the following cycle.
- **Full queue.** With `DERINLIK=4`, issue 5 back-to-back with no hazir. Required: `yurut_stall_o=1` after the fourth accept, the fifth is not accepted, and `doluluk_o=4`.
- **Flush with results in flight.** Issue 2 to unit 2, then `bosalt_i` before either completes; two hazir pulses for unit 2 then arrive. Required: both are dropped and `sonuc_gecerli_o` stays 0. A subsequent issue to unit 2 with result 0x33 then retires 0x33.
- **Bad select.** `birim_sec_i=4'b0011`. Required: `gecersiz_sec_o` pulses, `birim_baslat_o=0`, and `doluluk_o` is unchanged.
- **Freeze.** `durdur_i` held for 3 cycles while hazir arrives for the head with result 0x44. Required: no retire during the freeze, and retire of 0x44 one edge after `durdur_i` falls.
- **Reset mid-operation.** `rst_i` asserted with 3 entries queued. Required: all outputs 0, `doluluk_o=0`, and later hazir pulses are ignored.
